// File: rtl/ask_tx_scheduler.sv
// ASK modulator frame scheduler: 4-entry byte FIFO, preamble + MSB-first serialiser, inter-frame gap.
// Define ASK_TX_PARITY_EN to append an even-parity symbol after every data byte.
module ask_tx_scheduler #(
    parameter int unsigned SYM_DIV  = 512,
    parameter logic [7:0]  PREAMBLE = 8'hAA,
    parameter int unsigned GAP_SYM  = 2
) (
    input  logic       clk_,
    input  logic       reset_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       tx_bit,
    output logic       tx_en,
    output logic       sym_tick,
    output logic       busy,
    output logic [2:0] fifo_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
`ifdef ASK_TX_PARITY_EN
        ST_PAR  = 3'd3,
`endif
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [15:0] SYM_LAST = 16'(SYM_DIV - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_SYM - 1);

    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       s_ready_q;
    logic       push;
    logic       pop;
    logic [7:0] head;

    state_t      state_q;
    logic [15:0] sym_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  gap_cnt_q;
    logic [7:0]  shift_q;
`ifdef ASK_TX_PARITY_EN
    logic        par_q;
`endif
    logic        tx_bit_q;
    logic        tx_en_q;
    logic        sym_tick_q;
    logic        busy_q;

    logic sym_end;
    logic byte_end;
    logic fifo_nempty;

    assign push        = s_valid && s_ready_q;
    assign head        = mem_q[rd_ptr_q];
    assign sym_end     = (sym_cnt_q == SYM_LAST);
    assign byte_end    = sym_end && (bit_cnt_q == 3'd0);
    assign fifo_nempty = (cnt_q != 3'd0);

    // The FIFO head is popped on the same edge that loads it into the shifter.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_PRE:  pop = byte_end && fifo_nempty;
`ifdef ASK_TX_PARITY_EN
            ST_PAR:  pop = sym_end && fifo_nempty;
`else
            ST_DATA: pop = byte_end && fifo_nempty;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clk_ or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d != 3'd4);
        end
    end

    always_ff @(posedge clk_) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk_ or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sym_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef ASK_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            tx_bit_q   <= 1'b0;
            tx_en_q    <= 1'b0;
            sym_tick_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sym_tick_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                sym_cnt_q <= sym_end ? 16'd0 : sym_cnt_q + 16'd1;
            end
            if (pop) begin
                state_q    <= ST_DATA;
                shift_q    <= head;
                bit_cnt_q  <= 3'd7;
                tx_bit_q   <= head[7];
                sym_tick_q <= 1'b1;
`ifdef ASK_TX_PARITY_EN
                par_q      <= ^head;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fifo_nempty) begin
                            state_q    <= ST_PRE;
                            shift_q    <= PREAMBLE;
                            bit_cnt_q  <= 3'd7;
                            tx_en_q    <= 1'b1;
                            tx_bit_q   <= PREAMBLE[7];
                            sym_tick_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_PRE, ST_DATA: begin
                        if (sym_end) begin
                            if (bit_cnt_q != 3'd0) begin
                                bit_cnt_q  <= bit_cnt_q - 3'd1;
                                tx_bit_q   <= shift_q[bit_cnt_q - 3'd1];
                                sym_tick_q <= 1'b1;
                            end
`ifdef ASK_TX_PARITY_EN
                            else if (state_q == ST_DATA) begin
                                state_q    <= ST_PAR;
                                tx_bit_q   <= par_q;
                                sym_tick_q <= 1'b1;
                            end
`endif
                            else begin
                                state_q   <= ST_GAP;
                                tx_en_q   <= 1'b0;
                                tx_bit_q  <= 1'b0;
                                gap_cnt_q <= 4'd0;
                            end
                        end
                    end
`ifdef ASK_TX_PARITY_EN
                    ST_PAR: begin
                        if (sym_end) begin
                            state_q   <= ST_GAP;
                            tx_en_q   <= 1'b0;
                            tx_bit_q  <= 1'b0;
                            gap_cnt_q <= 4'd0;
                        end
                    end
`endif
                    ST_GAP: begin
                        if (sym_end) begin
                            if (gap_cnt_q == GAP_LAST) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                gap_cnt_q <= gap_cnt_q + 4'd1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_ready  = s_ready_q;
    assign fifo_cnt = cnt_q;
    assign tx_bit   = tx_bit_q;
    assign tx_en    = tx_en_q;
    assign sym_tick = sym_tick_q;
    assign busy     = busy_q;

endmodule

// File: doc/ask_tx_scheduler.md
# ask_tx_scheduler

Frame scheduler that feeds the ASK modulator datapath. It buffers bytes from an upstream requester in a 4-entry FIFO and wraps each burst in a fixed preamble. It serializes the burst MSB-first at a programmable symbol rate, driving the modulator's data input (`tx_bit`) and output-enable (`tx_en`). Between frames it enforces an inter-frame gap, with the modulator disabled.

## Interface
Parameters:
- `SYM_DIV`, default 512: `clk_` cycles per symbol. Legal range is 2..65535.
- `PREAMBLE`, default 8'hAA: preamble byte, sent MSB-first at the start of every frame.
- `GAP_SYM`, default 2: number of idle symbols after each frame, with `tx_en` low. Legal range is 1..15.

Ports:
- `clk_`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `s_valid`, input, 1: upstream byte valid.
- `s_data`, input, 8: upstream byte.
- `s_ready`, output, 1: FIFO can accept a byte. A byte transfers on a rising edge where `s_valid && s_ready`.
- `tx_bit`, output, 1: serial symbol to the modulator data input.
- `tx_en`, output, 1: modulator enable. 1 means modulated output; 0 means constant idle level.
- `sym_tick`, output, 1: one-cycle pulse on the first cycle of each symbol while a frame is active.
- `busy`, output, 1: FSM is not in IDLE.
- `fifo_cnt`, output, 3: FIFO occupancy, 0..4.

## Operation
- **FIFO.** 4 entries, registered pointers, and a 3-bit count.
  - `s_ready = (fifo_cnt != 4)`.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full cannot occur, because `s_ready` is low.
- **FSM states:** IDLE, PRE, DATA, PAR (present only with the macro), GAP.
  - IDLE → PRE when `fifo_cnt != 0`.
  - PRE → DATA after 8 symbols.
  - DATA → PAR after 8 symbols if parity is enabled; otherwise DATA → DATA if the FIFO is non-empty at the byte boundary, else DATA → GAP.
  - PAR → DATA if the FIFO is non-empty at the byte boundary, else PAR → GAP.
  - GAP → IDLE after `GAP_SYM` symbols.
- **Symbol counter** (16-bit) runs 0..`SYM_DIV`-1 in every non-IDLE state and is held at 0 in IDLE. Symbol boundaries occur where the counter is 0.
- **Bit counter** (3-bit) counts 7 down to 0 and selects the bit of the shift register.
  - The shift register loads `PREAMBLE` on entry to PRE.
  - It loads the FIFO head on entry to DATA, popping the FIFO on that same load cycle.
- **Frame boundary rule.** A byte pushed after the last DATA/PAR byte boundary has been evaluated is not sent in the current frame. It is sent in the next frame, after the GAP.
- **Outputs per state:**
  - `tx_en` = 1 in PRE, DATA and PAR; 0 in IDLE and GAP.
  - `tx_bit` = current shift bit in PRE and DATA, the parity bit in PAR, and 0 in IDLE and GAP.

## Timing
- **Reset values** (asynchronous `reset_n` low): state IDLE, all counters 0, FIFO empty.
  - Outputs: `s_ready`=1, `tx_bit`=0, `tx_en`=0, `sym_tick`=0, `busy`=0, `fifo_cnt`=0.
- **Reset mid-frame** aborts immediately: outputs take their reset values asynchronously and FIFO contents are discarded.
- **All outputs are registered.**
- **Start latency.** A push on edge N makes `fifo_cnt`=1 after N. At edge N+1 the FSM enters PRE; `tx_en`=1, `tx_bit`=`PREAMBLE[7]` and `sym_tick`=1 are all visible after N+1.
- **Symbol duration.** Each symbol lasts exactly `SYM_DIV` cycles. `tx_bit` changes only on symbol boundaries.
- **Frame length** is 8 + 8·B symbols without parity, or 8 + 9·B symbols with parity, where B is the number of bytes sent. GAP adds `GAP_SYM` symbols.
- **Pop timing.** The pop occurs on the boundary cycle at which the DATA byte's first bit is presented. `s_ready` rises on the following cycle if the FIFO was full.

## Configuration
- **`ASK_TX_PARITY_EN` defined:** each data byte is followed by one PAR symbol carrying even parity, so the 9 symbols have an even number of ones (`^byte`).
- **`ASK_TX_PARITY_EN` undefined:** the PAR state and parity logic are absent. Bytes are sent back-to-back.

## Test plan
1. Reset, then push 8'h3C with `SYM_DIV`=4 → `tx_en` is high for 64 cycles. `tx_bit` symbols are 1,0,1,0,1,0,1,0 then 0,0,1,1,1,1,0,0. `tx_en` is then low for 8 cycles (GAP), and `busy` falls.
2. Push 5 bytes back-to-back while idle → `s_ready` drops after the 4th push. It reasserts the cycle after the first pop (PRE→DATA entry). All 5 bytes are sent in one frame with no gap between bytes.
3. Push 1 byte, then push a 2nd byte one cycle after the first byte's final symbol boundary → the frame ends after the 1st byte, GAP is inserted, and the 2nd byte goes out in a new frame with its own preamble.
4. Assert `reset_n`=0 mid-DATA → `tx_en`, `tx_bit`, `busy` and `fifo_cnt` go to 0 without waiting for a clock edge. After release, the FSM stays IDLE until a new push.
5. With `ASK_TX_PARITY_EN`, send 8'h07 → the 9th data symbol is 1. Send 8'h03 → the 9th data symbol is 0. Frame length is 17 symbols.
6. With `SYM_DIV`=512, check `sym_tick` → the spacing between pulses is exactly 512 cycles throughout the frame, and there are no pulses in IDLE.
